// File: rtl/key_search_ctrl_if.sv
// Controller-side bus to the arcfour core and its decrypted-message RAM.
// Used by key_search_ctrl (master) and by the core/RAM side (slave).
interface key_search_ctrl_if #(
    parameter int KEY_W = 24,
    parameter int AW    = 5
);
    // start_sig rises with key stable and holds high until arcfour_finished is seen high
    // after having been seen low; mAddr is held while mOut settles RD_LAT cycles later.
    logic [KEY_W-1:0] key;
    logic             start_sig;
    logic             arcfour_finished;
    logic [AW-1:0]    mAddr;
    logic [7:0]       mOut;

    modport master (
        output key, start_sig, mAddr,
        input  arcfour_finished, mOut
    );

    modport slave (
        input  key, start_sig, mAddr,
        output arcfour_finished, mOut
    );
endinterface

// File: rtl/key_search_ctrl.sv
// Brute-force key search around the arcfour core: launch, wait, scan plaintext, step key.
// Define KSC_TAPS_EN to expose stateTap, idxTap and the keysTried run counter.
module key_search_ctrl #(
    parameter int               KEY_W   = 24,
    parameter logic [KEY_W-1:0] KEY_MIN = KEY_W'(24'h000000),
    parameter logic [KEY_W-1:0] KEY_MAX = KEY_W'(24'h3FFFFF),
    parameter int               MSG_LEN = 32,
    parameter int               RD_LAT  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  go,
    key_search_ctrl_if.master     arc,
    output logic                  busy,
    output logic                  found,
    output logic                  exhausted
`ifdef KSC_TAPS_EN
    ,
    output logic [3:0]                 stateTap,
    output logic [$clog2(MSG_LEN)-1:0] idxTap,
    output logic [KEY_W-1:0]           keysTried
`endif
);
    localparam int             AW       = $clog2(MSG_LEN);
    localparam logic [AW-1:0]  IDX_LAST = AW'(MSG_LEN - 1);
    localparam logic [1:0]     LAT_LAST = 2'(RD_LAT - 1);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        LAUNCH   = 4'd1,
        WAIT_ARC = 4'd2,
        RD_ISSUE = 4'd3,
        RD_WAIT  = 4'd4,
        CHECK    = 4'd5,
        NEXT_KEY = 4'd6,
        FOUND    = 4'd7,
        FAIL     = 4'd8
    } stateT;

    stateT         state;
    logic [AW-1:0] idx;
    logic [1:0]    latCnt;
    logic          seenLow;
    logic          goQ;
    logic          goRise;
    logic          byteOk;
    logic [1:0]    rstSync;
    logic          rstN;

    // Reset asserts immediately and releases two clocks later, in step with clk.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rstSync <= 2'b00;
        else        rstSync <= {rstSync[0], 1'b1};
    end
    assign rstN = rstSync[1];

    assign goRise = go & ~goQ;
    assign byteOk = ((arc.mOut >= 8'h61) && (arc.mOut <= 8'h7A)) || (arc.mOut == 8'h20);

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state         <= IDLE;
            arc.key       <= KEY_MIN;
            arc.start_sig <= 1'b0;
            arc.mAddr     <= '0;
            busy          <= 1'b0;
            found         <= 1'b0;
            exhausted     <= 1'b0;
            idx           <= '0;
            latCnt        <= 2'd0;
            seenLow       <= 1'b0;
            goQ           <= 1'b0;
`ifdef KSC_TAPS_EN
            keysTried     <= '0;
`endif
        end else begin
            goQ <= go;
            case (state)
                IDLE, FOUND, FAIL: begin
                    if (goRise) begin
                        arc.key   <= KEY_MIN;
                        found     <= 1'b0;
                        exhausted <= 1'b0;
                        busy      <= 1'b1;
                        state     <= LAUNCH;
`ifdef KSC_TAPS_EN
                        keysTried <= '0;
`endif
                    end
                end
                LAUNCH: begin
                    arc.start_sig <= 1'b1;
                    seenLow       <= 1'b0;
                    state         <= WAIT_ARC;
                end
                // A finished level left over from the previous run is ignored until it drops.
                WAIT_ARC: begin
                    if (!arc.arcfour_finished) begin
                        seenLow <= 1'b1;
                    end else if (seenLow) begin
                        arc.start_sig <= 1'b0;
                        idx           <= '0;
                        state         <= RD_ISSUE;
`ifdef KSC_TAPS_EN
                        keysTried     <= keysTried + KEY_W'(1);
`endif
                    end
                end
                RD_ISSUE: begin
                    arc.mAddr <= idx;
                    latCnt    <= 2'd0;
                    state     <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (latCnt == LAT_LAST) state <= CHECK;
                    else                    latCnt <= latCnt + 2'd1;
                end
                CHECK: begin
                    if (!byteOk) begin
                        state <= NEXT_KEY;
                    end else if (idx == IDX_LAST) begin
                        found <= 1'b1;
                        busy  <= 1'b0;
                        state <= FOUND;
                    end else begin
                        idx   <= idx + AW'(1);
                        state <= RD_ISSUE;
                    end
                end
                NEXT_KEY: begin
                    if (arc.key == KEY_MAX) begin
                        exhausted <= 1'b1;
                        busy      <= 1'b0;
                        state     <= FAIL;
                    end else begin
                        arc.key <= arc.key + KEY_W'(1);
                        state   <= LAUNCH;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef KSC_TAPS_EN
    assign stateTap = state;
    assign idxTap   = idx;
`endif
endmodule

// File: tb/tb_key_search_ctrl.sv
// Directed bench for key_search_ctrl: instance A (keys 0..5, RD_LAT=1), instance B (RD_LAT=2).
// Arcfour and RAM are small behavioural models; expected results are hand-computed.
module tb_key_search_ctrl;
    localparam int KW      = 24;
    localparam int AW      = 5;
    localparam int RUN_CYC = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstN;
    logic goA, goB;
    logic busyA, foundA, exhA;
    logic busyB, foundB, exhB;
    logic [7:0] memA, memB, pipeB;

    int checkCnt = 0;
    int failCnt  = 0;
    int mode     = 0;
    int staleCfg = 0;
    logic clrCnt = 1'b0;

    key_search_ctrl_if #(.KEY_W(KW), .AW(AW)) busA ();
    key_search_ctrl_if #(.KEY_W(KW), .AW(AW)) busB ();

`ifdef KSC_TAPS_EN
    logic [3:0] stA, stB;
    logic [AW-1:0] ixA, ixB;
    logic [KW-1:0] ktA, ktB;
`endif

    key_search_ctrl #(.KEY_W(KW), .KEY_MIN(24'h000000), .KEY_MAX(24'h000005),
                      .MSG_LEN(32), .RD_LAT(1)) dutA (
        .clk(clk), .reset(rstN), .go(goA), .arc(busA),
        .busy(busyA), .found(foundA), .exhausted(exhA)
`ifdef KSC_TAPS_EN
        , .stateTap(stA), .idxTap(ixA), .keysTried(ktA)
`endif
    );

    key_search_ctrl #(.KEY_W(KW), .MSG_LEN(32), .RD_LAT(2)) dutB (
        .clk(clk), .reset(rstN), .go(goB), .arc(busB),
        .busy(busyB), .found(foundB), .exhausted(exhB)
`ifdef KSC_TAPS_EN
        , .stateTap(stB), .idxTap(ixB), .keysTried(ktB)
`endif
    );

    logic          startV [2];
    logic [KW-1:0] keyV   [2];
    logic [AW-1:0] addrV  [2];
    logic          fin    [2];
    logic          running[2];
    logic          startQ [2];
    int            cnt    [2];
    int            staleCnt[2];

    assign startV[0] = busA.start_sig;
    assign startV[1] = busB.start_sig;
    assign keyV[0]   = busA.key;
    assign keyV[1]   = busB.key;
    assign addrV[0]  = busA.mAddr;
    assign addrV[1]  = busB.mAddr;
    assign busA.arcfour_finished = fin[0];
    assign busB.arcfour_finished = fin[1];
    assign busA.mOut = memA;
    assign busB.mOut = memB;

    // Arcfour model: on a start_sig rise, keep finished as it was for staleCfg cycles,
    // drop it for RUN_CYC cycles, then raise it and hold until the next launch.
    always @(posedge clk or negedge rstN) begin
        for (int i = 0; i < 2; i++) begin
            if (!rstN) begin
                fin[i] <= 1'b0; running[i] <= 1'b0; startQ[i] <= 1'b0;
                cnt[i] <= 0; staleCnt[i] <= 0;
            end else begin
                startQ[i] <= startV[i];
                if (startV[i] && !startQ[i]) begin
                    running[i] <= 1'b1; cnt[i] <= RUN_CYC; staleCnt[i] <= staleCfg;
                end else if (running[i]) begin
                    if (staleCnt[i] != 0)  staleCnt[i] <= staleCnt[i] - 1;
                    else if (cnt[i] != 0) begin fin[i] <= 1'b0; cnt[i] <= cnt[i] - 1; end
                    else begin fin[i] <= 1'b1; running[i] <= 1'b0; end
                end
            end
        end
    end

    function automatic logic [7:0] ramByte(input int m, input logic [KW-1:0] k, input logic [AW-1:0] a);
        logic [111:0] msg;
        msg = "attack at dawn";
        case (m)
            0: begin
                if (k != 24'h000003) return 8'hFF;
                if (a < 5'd14) return msg[8*(13-int'(a)) +: 8];
                return 8'h20;
            end
            1: return 8'h41;
            2: begin
                if (a == 5'd31) return 8'h7B;
                case (int'(a) % 3)
                    0: return 8'h61;
                    1: return 8'h7A;
                    default: return 8'h20;
                endcase
            end
            3: return (a == 5'd0) ? 8'h60 : 8'h61;
            default: return 8'h00;
        endcase
    endfunction

    always @(posedge clk) begin
        memA  <= ramByte(mode, keyV[0], addrV[0]);
        pipeB <= ramByte(0, keyV[1], addrV[1]);
        memB  <= pipeB;
    end

    int            pulses[2];
    int            staleViol[2];
    int            bothViol;
    logic          prevStart[2];
    logic [31:0]   maskA;
    logic [KW-1:0] keyLog[$];
    logic [KW-1:0] expQ[$];

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            prevStart[i] <= startV[i];
            if (clrCnt) begin
                pulses[i] <= 0; staleViol[i] <= 0;
            end else begin
                if (startV[i] && !prevStart[i]) pulses[i] <= pulses[i] + 1;
                if (running[i] && fin[i] && !startV[i]) staleViol[i] <= staleViol[i] + 1;
            end
        end
        if (clrCnt) begin
            maskA <= 32'h0; bothViol <= 0; keyLog.delete();
        end else begin
            if (startV[0] && !prevStart[0]) keyLog.push_back(keyV[0]);
            if (busyA && !startV[0]) maskA[addrV[0]] <= 1'b1;
            if ((foundA && exhA) || (foundB && exhB)) bothViol <= bothViol + 1;
        end
    end

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCnt++;
        if (got !== exp) begin
            failCnt++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic busyOf(input int inst);
        return (inst == 0) ? busyA : busyB;
    endfunction

    task automatic clearStats();
        @(posedge clk); clrCnt = 1'b1;
        @(posedge clk); clrCnt = 1'b0;
    endtask

    task automatic pulseReset();
        goA = 1'b0; goB = 1'b0;
        @(posedge clk); #1 rstN = 1'b0;
        repeat (3) @(posedge clk);
        #1 rstN = 1'b1;
        repeat (4) @(posedge clk);
    endtask

    task automatic runSearch(input int inst, input bit toggleGo);
        int n;
        clearStats();
        @(posedge clk); #1;
        if (inst == 0) goA = 1'b1; else goB = 1'b1;
        n = 0;
        while (!busyOf(inst) && n < 20) begin @(negedge clk); n++; end
        checkVal("busy_rise", 32'(busyOf(inst)), 32'd1);
        n = 0;
        while (busyOf(inst) && n < 4000) begin
            @(negedge clk); n++;
            if (toggleGo && n == 60) goA = 1'b0;
            if (toggleGo && n == 62) goA = 1'b1;
        end
        checkVal("search_done", 32'(busyOf(inst)), 32'd0);
        goA = 1'b0; goB = 1'b0;
    endtask

    task automatic checkFoundA(input string tag);
        checkVal({tag, "_found"}, 32'(foundA), 32'd1);
        checkVal({tag, "_exh"},   32'(exhA), 32'd0);
        checkVal({tag, "_key"},   32'(keyV[0]), 32'h3);
        checkVal({tag, "_pulses"}, 32'(pulses[0]), 32'd4);
    endtask

    task automatic checkExhA(input string tag, input logic [31:0] expMask);
        repeat (200) @(negedge clk);
        checkVal({tag, "_exh"},    32'(exhA), 32'd1);
        checkVal({tag, "_found"},  32'(foundA), 32'd0);
        checkVal({tag, "_key"},    32'(keyV[0]), 32'h5);
        checkVal({tag, "_pulses"}, 32'(pulses[0]), 32'd6);
        checkVal({tag, "_mask"},   maskA, expMask);
    endtask

    initial begin
        int falls, n;
        logic prev;
        rstN = 1'b1; goA = 1'b0; goB = 1'b0;
        #1 rstN = 1'b0;
        #139;
        checkVal("rst_start",  32'(startV[0]), 32'd0);
        checkVal("rst_busy",   32'(busyA), 32'd0);
        checkVal("rst_found",  32'(foundA), 32'd0);
        checkVal("rst_exh",    32'(exhA), 32'd0);
        checkVal("rst_key",    32'(keyV[0]), 32'd0);
        checkVal("rst_addr",   32'(addrV[0]), 32'd0);
        #11 rstN = 1'b1;
        repeat (4) @(posedge clk);

        // Key sweep to the plaintext key, with a go re-edge mid-search that must be ignored.
        mode = 0;
        runSearch(0, 1'b1);
        checkFoundA("sweep");
        checkVal("sweep_busy", 32'(busyA), 32'd0);
        checkVal("sweep_stale", 32'(staleViol[0]), 32'd0);
        expQ = '{24'h0, 24'h1, 24'h2, 24'h3};
        checkVal("keylog_len", 32'(keyLog.size()), 32'(expQ.size()));
        for (int i = 0; i < expQ.size() && i < keyLog.size(); i++)
            checkVal("keylog", 32'(keyLog[i]), 32'(expQ[i]));

        pulseReset(); mode = 1; runSearch(0, 1'b0); checkExhA("allA", 32'h0000_0001);
        pulseReset(); mode = 2; runSearch(0, 1'b0); checkExhA("last7B", 32'hFFFF_FFFF);
        pulseReset(); mode = 3; runSearch(0, 1'b0); checkExhA("first60", 32'h0000_0001);

        // Long stale finished level on every relaunch.
        pulseReset(); mode = 0; staleCfg = 5;
        runSearch(0, 1'b0);
        checkFoundA("stale");
        checkVal("stale_viol", 32'(staleViol[0]), 32'd0);
        staleCfg = 0;

        // Reset during RD_WAIT of key 2, then a clean restart.
        pulseReset(); mode = 0; clearStats();
        @(posedge clk); #1 goA = 1'b1;
        falls = 0; n = 0; prev = 1'b0;
        while (falls < 3 && n < 2000) begin
            @(negedge clk); n++;
            if (prev && !startV[0]) falls++;
            prev = startV[0];
        end
        checkVal("mid_falls", 32'(falls), 32'd3);
        checkVal("mid_busy_pre", 32'(busyA), 32'd1);
        @(posedge clk); #2 rstN = 1'b0;
        #1;
        checkVal("mid_start", 32'(startV[0]), 32'd0);
        checkVal("mid_busy",  32'(busyA), 32'd0);
        checkVal("mid_key",   32'(keyV[0]), 32'd0);
        checkVal("mid_found", 32'(foundA), 32'd0);
        goA = 1'b0;
        repeat (3) @(posedge clk);
        #1 rstN = 1'b1;
        repeat (4) @(posedge clk);
        runSearch(0, 1'b0);
        checkFoundA("restart");

        // Two-cycle read latency finds the same key.
        runSearch(1, 1'b0);
        checkVal("lat2_found",  32'(foundB), 32'd1);
        checkVal("lat2_exh",    32'(exhB), 32'd0);
        checkVal("lat2_key",    32'(keyV[1]), 32'h3);
        checkVal("lat2_pulses", 32'(pulses[1]), 32'd4);
        checkVal("lat2_stale",  32'(staleViol[1]), 32'd0);
        checkVal("both_flags",  32'(bothViol), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCnt, failCnt);
        $finish;
    end
endmodule
